// File: rtl/seg_capture_pkg.sv
// -----------------------------------------------------------------------------
// seg_capture_pkg
// Shared definitions for the 7-segment readback capture block:
//   - active-low segment patterns {g,f,e,d,c,b,a} for digits 0-9 and blank
//   - capture FSM state encoding
//   - scan slot indices (slot N is driven while an[N] is low)
//   - decode result struct and the anode-to-slot helper
// -----------------------------------------------------------------------------
package seg_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_COLLECT = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  localparam logic [1:0] SLOT0 = 2'd0;
  localparam logic [1:0] SLOT1 = 2'd1;
  localparam logic [1:0] SLOT2 = 2'd2;
  localparam logic [1:0] SLOT3 = 2'd3;

  typedef struct packed {
    logic       blank;
    logic       err;
    logic [3:0] digit;
  } seg_dec_t;

  // Returns {valid, slot}; valid only when exactly one anode is driven low.
  function automatic logic [2:0] an_to_slot(input logic [3:0] an);
    logic [2:0] res;
    case (an)
      4'b0111: res = {1'b1, SLOT3};
      4'b1011: res = {1'b1, SLOT2};
      4'b1101: res = {1'b1, SLOT1};
      4'b1110: res = {1'b1, SLOT0};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational inverse of the 7-segment encoder.
//   i: seg [6:0]  active-low segments {g,f,e,d,c,b,a}
//   o: dec        {blank, err, digit}; blank reads digit 0, unknown reads 4'hF
// -----------------------------------------------------------------------------
module seg7_decode
  import seg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output seg_dec_t   dec
);

  // Pattern lookup; anything outside the digit/blank table is flagged.
  always_comb begin
    dec = '{blank: 1'b0, err: 1'b0, digit: 4'h0};
    case (seg)
      SEG_0:     dec.digit = 4'd0;
      SEG_1:     dec.digit = 4'd1;
      SEG_2:     dec.digit = 4'd2;
      SEG_3:     dec.digit = 4'd3;
      SEG_4:     dec.digit = 4'd4;
      SEG_5:     dec.digit = 4'd5;
      SEG_6:     dec.digit = 4'd6;
      SEG_7:     dec.digit = 4'd7;
      SEG_8:     dec.digit = 4'd8;
      SEG_9:     dec.digit = 4'd9;
      SEG_BLANK: dec.blank = 1'b1;
      default: begin
        dec.err   = 1'b1;
        dec.digit = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/seg_display_capture.sv
// -----------------------------------------------------------------------------
// seg_display_capture
// Watches a multiplexed 7-segment drive (an/seg), decodes each scanned digit
// back to BCD and publishes complete MT:MO:ST:SO frames on a valid/ready port.
// A frame is one scan of anodes 3,2,1,0 in that order.
//
// Parameters: SETTLE_CYCLES  - clk cycles {an,seg} must hold before sampling
//             TIMEOUT_CYCLES - clk cycles without a captured digit -> stalled
// Ports:
//   clk, rst_n (async active-low)
//   an[3:0], seg[6:0]     active-low display drive, asynchronous to clk
//   mt, mo, st, so        captured digits for an[3]..an[0] (4'hF = undecodable)
//   blank, digit_err      per-slot flags, bit N belongs to an[N]
//   out_valid/out_ready   frame handshake; outputs hold while stalled by ready
//   overrun, seq_err      sticky error flags, cleared by clr_flags pulse
//   stalled               no digit captured for TIMEOUT_CYCLES
// Build option: SEG_CAPTURE_CHANGE_ONLY_EN - publish only frames that differ
//   from the last published one (identical frames are dropped silently).
// -----------------------------------------------------------------------------
module seg_display_capture
  import seg_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic [3:0] blank,
  output logic [3:0] digit_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  output logic       seq_err,
  output logic       stalled,
  input  logic       clr_flags
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [10:0]           r_sync1;
  logic [10:0]           r_sync2;
  logic [10:0]           r_last;
  logic [SC_W-1:0]       r_stab_cnt;
  logic [TO_W-1:0]       r_to_cnt;

  state_t                r_state;
  seg_dec_t [3:0]        r_slot;
  seg_dec_t [3:0]        r_out_slot;
  logic [1:0]            r_last_slot;
  logic                  r_await_start;
  logic                  r_out_valid;
  logic                  r_overrun;
  logic                  r_seq_err;
  logic                  r_stalled;
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
  logic                  r_pub_seen;
`endif

  logic                  w_changed;
  logic                  w_sample;
  logic [2:0]            w_slot_info;
  logic [1:0]            w_slot;
  logic                  w_to_hit;
  logic                  w_dup;
  seg_dec_t              w_dec;

  // Two-flop synchronizer on the whole display bus; idle value is all-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 11'h7FF;
      r_sync2 <= 11'h7FF;
    end else begin
      r_sync1 <= {an, seg};
      r_sync2 <= r_sync1;
    end
  end

  assign w_changed   = (r_sync2 != r_last);
  assign w_slot_info = an_to_slot(r_last[10:7]);
  assign w_slot      = w_slot_info[1:0];
  // Exactly one sample per stable period: the counter passes SETTLE-1 once and then parks.
  assign w_sample    = !w_changed && (r_stab_cnt == SC_W'(SETTLE_CYCLES - 1)) && w_slot_info[2];
  assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  // Stability counter: restarts on any bus change, saturates at SETTLE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= 11'h7FF;
      r_stab_cnt <= '0;
    end else begin
      r_last <= r_sync2;
      if (w_changed) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != SC_W'(SETTLE_CYCLES)) begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  // Idle timer between captured digits, saturating at TIMEOUT_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_sample) begin
      r_to_cnt <= '0;
    end else if (!w_to_hit) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  seg7_decode u_decode (
    .seg (r_last[6:0]),
    .dec (w_dec)
  );

  // The holding register always holds the last published frame, so it doubles as the compare reference.
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
  assign w_dup = r_pub_seen && (r_slot == r_out_slot);
`else
  assign w_dup = 1'b0;
`endif

  // Capture FSM, holding register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_SYNC;
      r_slot        <= '0;
      r_out_slot    <= '0;
      r_last_slot   <= SLOT3;
      r_await_start <= 1'b0;
      r_out_valid   <= 1'b0;
      r_overrun     <= 1'b0;
      r_seq_err     <= 1'b0;
      r_stalled     <= 1'b0;
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
      r_pub_seen    <= 1'b0;
`endif
    end else begin
      // Clears first so that a same-cycle error set below wins.
      if (clr_flags) begin
        r_overrun <= 1'b0;
        r_seq_err <= 1'b0;
      end
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_sample) begin
        r_stalled <= 1'b0;
      end else if (w_to_hit) begin
        r_stalled <= 1'b1;
      end

      case (r_state)
        S_SYNC: begin
          if (w_sample && (w_slot == SLOT3)) begin
            r_slot[SLOT3] <= w_dec;
            r_last_slot   <= SLOT3;
            r_await_start <= 1'b0;
            r_state       <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_sample) begin
            if (r_await_start) begin
              // Just published: wait quietly for the next slot3, like S_SYNC.
              if (w_slot == SLOT3) begin
                r_slot[SLOT3] <= w_dec;
                r_last_slot   <= SLOT3;
                r_await_start <= 1'b0;
              end
            end else if (w_slot == r_last_slot) begin
              r_slot[w_slot] <= w_dec;
            end else if (w_slot == (r_last_slot - 2'd1)) begin
              r_slot[w_slot] <= w_dec;
              r_last_slot    <= w_slot;
              if (w_slot == SLOT0) begin
                r_state <= S_PUBLISH;
              end
            end else if (w_slot == SLOT3) begin
              r_slot[SLOT3] <= w_dec;
              r_last_slot   <= SLOT3;
            end else begin
              r_seq_err <= 1'b1;
              r_state   <= S_SYNC;
            end
          end else if (w_to_hit) begin
            r_state <= S_SYNC;
          end
        end
        S_PUBLISH: begin
          if (w_dup) begin
            r_out_slot <= r_out_slot;
          end else if (!r_out_valid || out_ready) begin
            r_out_slot  <= r_slot;
            r_out_valid <= 1'b1;
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
            r_pub_seen  <= 1'b1;
`endif
          end else begin
            r_overrun <= 1'b1;
          end
          r_await_start <= 1'b1;
          r_state       <= S_COLLECT;
        end
        default: begin
          r_state <= S_SYNC;
        end
      endcase
    end
  end

  assign mt        = r_out_slot[3].digit;
  assign mo        = r_out_slot[2].digit;
  assign st        = r_out_slot[1].digit;
  assign so        = r_out_slot[0].digit;
  assign blank     = {r_out_slot[3].blank, r_out_slot[2].blank, r_out_slot[1].blank, r_out_slot[0].blank};
  assign digit_err = {r_out_slot[3].err, r_out_slot[2].err, r_out_slot[1].err, r_out_slot[0].err};
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign seq_err   = r_seq_err;
  assign stalled   = r_stalled;

endmodule

// File: tb/tb_seg_display_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_display_capture
// Scoreboard bench: each scanned frame pushes its expected decode into a queue;
// a monitor pops and compares on every out_valid && out_ready handshake.
// -----------------------------------------------------------------------------
module tb_seg_display_capture;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] an;
  logic [6:0] seg;
  logic [3:0] mt, mo, st, so, blank, digit_err;
  logic       out_valid, out_ready, overrun, seq_err, stalled, clr_flags;

  seg_display_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
    .mt(mt), .mo(mo), .st(st), .so(so), .blank(blank), .digit_err(digit_err),
    .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .seq_err(seq_err), .stalled(stalled), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  logic [6:0]  pat_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [23:0] exp_q [$];
  logic [23:0] last_pub;
  bit          pub_seen;
  int          n_chk  = 0;
  int          n_pass = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // {blank, err, digit} straight from the pattern table.
  function automatic logic [5:0] ref_decode(logic [6:0] p);
    if (p == 7'h7F) return {1'b1, 1'b0, 4'h0};
    for (int i = 0; i < 10; i++) if (pat_tbl[i] == p) return {2'b00, 4'(i)};
    return {1'b0, 1'b1, 4'hF};
  endfunction

  // Frame image laid out as {mt,mo,st,so,blank[3:0],digit_err[3:0]}.
  function automatic logic [23:0] ref_frame(logic [6:0] p3, logic [6:0] p2, logic [6:0] p1, logic [6:0] p0);
    logic [5:0] d [4];
    d[3] = ref_decode(p3); d[2] = ref_decode(p2); d[1] = ref_decode(p1); d[0] = ref_decode(p0);
    return {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0],
            d[3][5], d[2][5], d[1][5], d[0][5],
            d[3][4], d[2][4], d[1][4], d[0][4]};
  endfunction

  function automatic void expect_publish(logic [23:0] f);
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
    if (pub_seen && f == last_pub) return;
`endif
    exp_q.push_back(f);
    last_pub = f;
    pub_seen = 1'b1;
  endfunction

  function automatic logic [6:0] rand_pat();
    int k;
    logic [6:0] p;
    k = $urandom_range(0, 11);
    if (k < 10) return pat_tbl[k];
    if (k == 10) return 7'h7F;
    p = 7'($urandom_range(0, 127));
    while (ref_decode(p) != {1'b0, 1'b1, 4'hF}) p = 7'($urandom_range(0, 127));
    return p;
  endfunction

  wire [23:0] act_frame = {mt, mo, st, so, blank, digit_err};

  // Monitor: one pop per handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_frame: got %h expected none", act_frame);
      end else begin
        check("frame", {8'h0, act_frame}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_slot(int slot, logic [6:0] p);
    logic [3:0] oh;
    oh  = 4'b0001 << slot;
    an  = ~oh;
    seg = p;
    step(8);
    an  = 4'hF;
    seg = 7'h7F;
    step(1);
  endtask

  task automatic scan_frame(logic [6:0] p3, logic [6:0] p2, logic [6:0] p1, logic [6:0] p0, bit pub);
    if (pub) expect_publish(ref_frame(p3, p2, p1, p0));
    scan_slot(3, p3); scan_slot(2, p2); scan_slot(1, p1); scan_slot(0, p0);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_valid"},  {31'h0, out_valid}, 32'h0);
    check({tag, "_overrun"},{31'h0, overrun},   32'h0);
    check({tag, "_seq_err"},{31'h0, seq_err},   32'h0);
    check({tag, "_stalled"},{31'h0, stalled},   32'h0);
    check({tag, "_frame"},  {8'h0, act_frame},  32'h0);
  endtask

  initial begin
    logic [6:0] p [4];
    logic [23:0] f1;
    int t;
    rst_n = 1'b0; an = 4'hF; seg = 7'h7F; out_ready = 1'b1; clr_flags = 1'b0;
    pub_seen = 1'b0; last_pub = '0;
    step(3);
    check_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Directed frame 2,9,3,5.
    scan_frame(7'h24, 7'h10, 7'h30, 7'h12, 1'b1);

    // Backpressure across two frames: first held, second dropped.
    out_ready = 1'b0;
    f1 = ref_frame(7'h79, 7'h19, 7'h78, 7'h00);
    scan_frame(7'h79, 7'h19, 7'h78, 7'h00, 1'b1);
    scan_frame(7'h79, 7'h19, 7'h78, 7'h02, 1'b0);
    step(2);
    check("ovr_set", {31'h0, overrun}, 32'h1);
    check("held_valid", {31'h0, out_valid}, 32'h1);
    check("held_frame", {8'h0, act_frame}, {8'h0, f1});
    clr_flags = 1'b1; step(1); clr_flags = 1'b0; step(1);
    check("ovr_clr", {31'h0, overrun}, 32'h0);
    out_ready = 1'b1;
    step(3);

    // Out-of-order scan: 7 then D.
    scan_slot(3, 7'h40); scan_slot(1, 7'h79);
    step(2);
    check("seq_err", {31'h0, seq_err}, 32'h1);
    scan_frame(7'h40, 7'h40, 7'h40, 7'h79, 1'b1);

    // Blank and undecodable digits.
    scan_frame(7'h12, 7'h6A, 7'h7F, 7'h00, 1'b1);

    // Randomized frames.
    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 4; j++) p[j] = rand_pat();
      scan_frame(p[3], p[2], p[1], p[0], 1'b1);
    end

    // Identical frame three times, then one changed digit.
    for (int i = 0; i < 3; i++) scan_frame(7'h24, 7'h10, 7'h30, 7'h12, 1'b1);
    scan_frame(7'h24, 7'h10, 7'h30, 7'h02, 1'b1);

    // Reset in mid-frame (seq_err still set, frame non-zero).
    scan_slot(3, 7'h30); scan_slot(2, 7'h30);
    rst_n = 1'b0;
    #2;
    check_zero("midrst");
    step(2);
    rst_n = 1'b1;
    pub_seen = 1'b0;
    step(2);
    scan_frame(7'h78, 7'h78, 7'h12, 7'h19, 1'b1);

    // Glitching bus never settles, then idle until stalled.
    an = 4'b0111;
    for (int i = 0; i < 15; i++) begin
      seg = (i % 2 == 0) ? 7'h40 : 7'h79;
      step(2);
    end
    an = 4'hF; seg = 7'h7F;
    t = 0;
    while (!stalled && t < 4 * TMO) begin step(1); t++; end
    check("stalled_set", {31'h0, stalled}, 32'h1);
    expect_publish(ref_frame(7'h02, 7'h30, 7'h79, 7'h10));
    scan_slot(3, 7'h02);
    check("stalled_clr", {31'h0, stalled}, 32'h0);
    scan_slot(2, 7'h30); scan_slot(1, 7'h79); scan_slot(0, 7'h10);

    // Drain.
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin step(1); t++; end
    check("queue_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
